// File: rtl/ex_mem_pipe_reg_if.sv
// EX/MEM beat bundle: valid/ready handshake plus the pipeline-latch fields.
// master drives a beat, slave accepts it.
interface ex_mem_pipe_reg_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned WB_CTL_W = 2,
  parameter int unsigned M_CTL_W  = 3
);
  logic                valid;
  logic                ready;
  logic [WB_CTL_W-1:0] wb_ctl;
  logic [M_CTL_W-1:0]  m_ctl;
  logic [DATA_W-1:0]   add_result;
  logic                zero;
  logic [DATA_W-1:0]   alu_result;
  logic [DATA_W-1:0]   rdata2;
  logic [RADDR_W-1:0]  dst;

  modport master (
    output valid, wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dst,
    input  ready
  );

  modport slave (
    input  valid, wb_ctl, m_ctl, add_result, zero, alu_result, rdata2, dst,
    output ready
  );
endinterface

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with a two-entry skid buffer, synchronous flush
// and a saturating back-pressure counter; in_ready is a flop output.
module ex_mem_pipe_reg #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RADDR_W  = 5,
  parameter int unsigned WB_CTL_W = 2,
  parameter int unsigned M_CTL_W  = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  ex_mem_pipe_reg_if.slave  in_if,
  ex_mem_pipe_reg_if.master out_if,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_cnt_clr
);

  typedef struct packed {
    logic [WB_CTL_W-1:0] wb_ctl;
    logic [M_CTL_W-1:0]  m_ctl;
    logic [DATA_W-1:0]   add_result;
    logic                zero;
    logic [DATA_W-1:0]   alu_result;
    logic [DATA_W-1:0]   rdata2;
    logic [RADDR_W-1:0]  dst;
  } beat_t;

  beat_t             in_beat;
  beat_t             main_q, main_d;
  beat_t             skid_q, skid_d;
  logic              main_vld_q, main_vld_d;
  logic              skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;
  logic              drain;

  assign in_beat = '{
    wb_ctl:     in_if.wb_ctl,
    m_ctl:      in_if.m_ctl,
    add_result: in_if.add_result,
    zero:       in_if.zero,
    alu_result: in_if.alu_result,
    rdata2:     in_if.rdata2,
    dst:        in_if.dst
  };

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready combinationally.
  assign in_if.ready = ~skid_vld_q;
  assign accept      = in_if.valid & ~skid_vld_q;
  assign drain       = main_vld_q & out_if.ready;

  always_comb begin
    main_d     = main_q;
    skid_d     = skid_q;
    main_vld_d = main_vld_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      // Bubbles keep their data but lose all side-effecting control.
      main_vld_d    = 1'b0;
      skid_vld_d    = 1'b0;
      main_d.wb_ctl = '0;
      main_d.m_ctl  = '0;
      skid_d.wb_ctl = '0;
      skid_d.m_ctl  = '0;
    end else if (!main_vld_q) begin
      if (accept) begin
        main_d     = in_beat;
        main_vld_d = 1'b1;
      end
    end else if (drain) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d = in_beat;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_beat;
      skid_vld_d = 1'b1;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_cnt_clr) begin
      cnt_d = '0;
    end else if (main_vld_q && !out_if.ready && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_if.valid      = main_vld_q;
  assign out_if.wb_ctl     = main_q.wb_ctl;
  assign out_if.m_ctl      = main_q.m_ctl;
  assign out_if.add_result = main_q.add_result;
  assign out_if.zero       = main_q.zero;
  assign out_if.alu_result = main_q.alu_result;
  assign out_if.rdata2     = main_q.rdata2;
  assign out_if.dst        = main_q.dst;
  assign stall_cnt         = cnt_q;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed bench: a default-width instance checked against a two-deep FIFO
// scoreboard, and a 64-bit/CNT_W=4 instance for saturation and wide fields.
module tb_ex_mem_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        flush0, clr0, flush1, clr1;
  logic [15:0] stall0;
  logic [3:0]  stall1;

  ex_mem_pipe_reg_if a_in ();
  ex_mem_pipe_reg_if a_out ();
  ex_mem_pipe_reg_if #(.DATA_W(64), .RADDR_W(6)) b_in ();
  ex_mem_pipe_reg_if #(.DATA_W(64), .RADDR_W(6)) b_out ();

  ex_mem_pipe_reg dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush0),
    .in_if(a_in), .out_if(a_out),
    .stall_cnt(stall0), .stall_cnt_clr(clr0)
  );

  ex_mem_pipe_reg #(.DATA_W(64), .RADDR_W(6), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_if(b_in), .out_if(b_out),
    .stall_cnt(stall1), .stall_cnt_clr(clr1)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] add;
    logic        zero;
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  dst;
  } beat_t;

  beat_t       sb[$];
  int unsigned stall_m;
  bit          flushed_m;
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check0();
    chk("out_valid", a_out.valid, sb.size() > 0);
    chk("in_ready", a_in.ready, sb.size() < 2);
    chk("stall_cnt", stall0, stall_m);
    if (sb.size() > 0) begin
      chk("alu_result", a_out.alu_result, sb[0].alu);
      chk("add_result", a_out.add_result, sb[0].add);
      chk("rdata2", a_out.rdata2, sb[0].rd2);
      chk("dst", a_out.dst, sb[0].dst);
      chk("zero", a_out.zero, sb[0].zero);
      chk("wb_ctl", a_out.wb_ctl, sb[0].wb);
      chk("m_ctl", a_out.m_ctl, sb[0].m);
    end else if (flushed_m) begin
      chk("flush_wb_ctl", a_out.wb_ctl, 0);
      chk("flush_m_ctl", a_out.m_ctl, 0);
    end
  endtask

  // One clock of dut0: drive inputs, advance the scoreboard model, compare.
  task automatic step0(input logic v, input logic [31:0] alu, input logic [1:0] wb,
                       input logic [2:0] m, input logic fl, input logic ordy,
                       input logic clr);
    beat_t b;
    bit    acc, drn;
    b.wb = wb; b.m = m; b.alu = alu; b.add = alu + 32'h100;
    b.rd2 = ~alu; b.dst = alu[4:0]; b.zero = (alu[3:0] == 4'h0);
    a_in.valid      = v;
    a_in.wb_ctl     = b.wb;
    a_in.m_ctl      = b.m;
    a_in.alu_result = b.alu;
    a_in.add_result = b.add;
    a_in.rdata2     = b.rd2;
    a_in.dst        = b.dst;
    a_in.zero       = b.zero;
    flush0          = fl;
    a_out.ready     = ordy;
    clr0            = clr;
    acc = v && (sb.size() < 2);
    drn = (sb.size() > 0) && ordy;
    if (clr) stall_m = 0;
    else if (sb.size() > 0 && !ordy && stall_m < 65535) stall_m++;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      flushed_m = 1'b1;
    end else begin
      if (drn) void'(sb.pop_front());
      if (acc) begin
        sb.push_back(b);
        flushed_m = 1'b0;
      end
    end
    #1;
    check0();
  endtask

  initial begin
    rst_n = 1'b0;
    stall_m = 0; flushed_m = 1'b0;
    a_in.valid = 1'b0; a_in.wb_ctl = '0; a_in.m_ctl = '0; a_in.alu_result = '0;
    a_in.add_result = '0; a_in.rdata2 = '0; a_in.dst = '0; a_in.zero = 1'b0;
    a_out.ready = 1'b1; flush0 = 1'b0; clr0 = 1'b0;
    b_in.valid = 1'b0; b_in.wb_ctl = '0; b_in.m_ctl = '0; b_in.alu_result = '0;
    b_in.add_result = '0; b_in.rdata2 = '0; b_in.dst = '0; b_in.zero = 1'b0;
    b_out.ready = 1'b1; flush1 = 1'b0; clr1 = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check0();
    chk("rst_alu", a_out.alu_result, 0);
    chk("rst_wb", a_out.wb_ctl, 0);
    chk("rst1_valid", b_out.valid, 0);
    chk("rst1_ready", b_in.ready, 1);
    chk("rst1_stall", stall1, 0);
    rst_n = 1'b1;

    // Streaming
    step0(1, 32'h10, 2'b01, 3'b001, 0, 1, 0);
    step0(1, 32'h20, 2'b10, 3'b010, 0, 1, 0);
    step0(1, 32'h30, 2'b11, 3'b011, 0, 1, 0);
    step0(1, 32'h40, 2'b01, 3'b100, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);
    chk("stream_stall", stall0, 0);

    // Back-pressure: out_ready low for three cycles, C held until accepted
    step0(1, 32'hA, 2'b01, 3'b001, 0, 1, 0);
    step0(1, 32'hB, 2'b10, 3'b010, 0, 0, 0);
    step0(1, 32'hC, 2'b11, 3'b011, 0, 0, 0);
    chk("bp_in_ready_low", a_in.ready, 0);
    step0(1, 32'hC, 2'b11, 3'b011, 0, 0, 0);
    step0(1, 32'hC, 2'b11, 3'b011, 0, 1, 0);
    step0(1, 32'hC, 2'b11, 3'b011, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);
    chk("bp_stall", stall0, 3);

    // Flush with main and skid full and a beat offered in the same cycle
    step0(1, 32'hD0, 2'b11, 3'b101, 0, 0, 0);
    step0(1, 32'hE0, 2'b11, 3'b101, 0, 0, 0);
    step0(1, 32'hF0, 2'b11, 3'b101, 1, 0, 0);
    chk("flush_ready", a_in.ready, 1);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);

    // Counter clear
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 1);
    chk("clr_stall", stall0, 0);

    // Async reset between edges with skid full
    step0(1, 32'h55, 2'b01, 3'b001, 0, 0, 0);
    step0(1, 32'h66, 2'b10, 3'b010, 0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete(); stall_m = 0; flushed_m = 1'b0;
    chk("arst_valid", a_out.valid, 0);
    chk("arst_ready", a_in.ready, 1);
    chk("arst_stall", stall0, 0);
    chk("arst_alu", a_out.alu_result, 0);
    chk("arst_wb", a_out.wb_ctl, 0);
    chk("arst_m", a_out.m_ctl, 0);
    chk("arst_dst", a_out.dst, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step0(1, 32'h77, 2'b01, 3'b010, 0, 1, 0);
    step0(0, 32'h0, 2'b00, 3'b000, 0, 1, 0);

    // Wide instance: hold one beat stalled to saturate the 4-bit counter
    b_in.valid = 1'b1;
    b_in.alu_result = 64'hFFFF_FFFF_0000_0001;
    b_in.add_result = 64'h8000_0000_0000_0000;
    b_in.rdata2 = 64'h0123_4567_89AB_CDEF;
    b_in.dst = 6'd63; b_in.wb_ctl = 2'b01; b_in.m_ctl = 3'b010; b_in.zero = 1'b1;
    b_out.ready = 1'b0;
    @(posedge clk);
    #1;
    b_in.valid = 1'b0;
    chk("w_valid", b_out.valid, 1);
    chk("w_stall0", stall1, 0);
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      chk("w_stall_sat", stall1, (i > 15) ? 15 : i);
    end
    chk("w_alu", b_out.alu_result, 64'hFFFF_FFFF_0000_0001);
    chk("w_add", b_out.add_result, 64'h8000_0000_0000_0000);
    chk("w_rdata2", b_out.rdata2, 64'h0123_4567_89AB_CDEF);
    chk("w_dst", b_out.dst, 63);
    chk("w_wb", b_out.wb_ctl, 2'b01);
    chk("w_m", b_out.m_ctl, 3'b010);
    chk("w_zero", b_out.zero, 1);
    clr1 = 1'b1;
    @(posedge clk);
    #1;
    clr1 = 1'b0;
    chk("w_clr_over_stall", stall1, 0);
    chk("w_still_valid", b_out.valid, 1);
    b_out.ready = 1'b1;
    @(posedge clk);
    #1;
    chk("w_drained", b_out.valid, 0);
    chk("w_stall_hold", stall1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
# ex_mem_pipe_reg

Parametrised EX/MEM pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush and a saturating back-pressure counter. It sits between the execute stage (ALU, branch adder, destination-register mux) and the memory stage. It carries the same fields as the fixed-width EX/MEM latch, but lets the memory stage stall without a combinational ready path back into execute.

## Interface
- DATA_W, 32: width of branch-target, ALU-result and store-data fields
- RADDR_W, 5: width of destination register number
- WB_CTL_W, 2: width of write-back control bundle
- M_CTL_W, 3: width of memory control bundle
- CNT_W, 16: width of stall counter

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  execute stage presents a beat
- in_ready  out  1  stage can accept a beat (registered)
- flush  in  1  synchronous kill of all held and incoming beats
- in_wb_ctl  in  WB_CTL_W  write-back control
- in_m_ctl  in  M_CTL_W  memory control
- in_add_result  in  DATA_W  branch target
- in_zero  in  1  ALU zero flag
- in_alu_result  in  DATA_W  ALU result / address
- in_rdata2  in  DATA_W  store data
- in_dst  in  RADDR_W  destination register
- out_valid  out  1  beat presented to memory stage
- out_ready  in  1  memory stage accepts beat
- out_wb_ctl, out_m_ctl, out_add_result, out_zero, out_alu_result, out_rdata2, out_dst  out  same widths  registered copies of the main entry
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
- stall_cnt_clr  in  1  synchronous clear of stall_cnt

## Operation
- Storage: main entry (drives outputs) plus skid entry. Each entry holds all fields and a valid bit.
- Invariant: skid valid implies main valid.
- Signal definitions:
  - in_ready = NOT skid_valid.
  - accept = in_valid AND in_ready.
  - drain = out_valid AND out_ready.
  - out_valid = main_valid.
- Per-cycle update when flush=0:
  - main empty, accept: main <= input.
  - main full, drain, skid empty, accept: main <= input.
  - main full, drain, skid empty, no accept: main_valid <= 0. Fields hold.
  - main full, no drain, accept: skid <= input, skid_valid <= 1.
  - main full, drain, skid full: main <= skid, skid_valid <= 0. No accept is possible because in_ready=0.
  - All other combinations: hold.
- Beats leave in acceptance order. None is dropped or duplicated.
- Flush (highest priority):
  - main_valid <= 0 and skid_valid <= 0.
  - The wb_ctl and m_ctl fields of both entries are zeroed, so a bubble can never write a register or memory.
  - The other fields hold.
  - A beat offered in the flush cycle is discarded even if in_ready=1.
  - A drain in the flush cycle still counts as consumed by the memory stage.
- stall_cnt:
  - Increments when out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - stall_cnt_clr forces 0 and wins over increment.
  - flush does not affect it.
- Reset: every output register, the skid entry and both valid bits go to 0. in_ready therefore reads 1 after reset.

## Timing
- Latency: a beat accepted at edge N is presented on out_* after edge N with out_valid=1, i.e. one cycle.
- Throughput: one beat per cycle while out_ready=1.
- in_ready is a flop output. No combinational path from out_ready to in_ready.
- When out_ready drops, one further beat is absorbed into the skid entry. in_ready goes low on the following edge.
- When out_ready returns with skid full, in_ready rises one edge later. The skid beat is presented at that same edge.
- Outputs are stable while out_valid=1 and out_ready=0.
- rst_n asserted mid-transfer clears state immediately, independent of clk. Operation resumes on the first edge after deassertion with empty entries.

## Test plan
- Streaming: out_ready=1, in_valid=1 for 4 beats with alu_result 0x10, 0x20, 0x30, 0x40 -> out_valid from cycle 1; the same values appear in order, one per cycle; stall_cnt=0.
- Back-pressure: stream 0xA, 0xB, 0xC with out_ready=0 from cycle 1 to cycle 3 ->
  - 0xA is held on the outputs.
  - 0xB is stored in the skid entry; in_ready=0 from cycle 2 until out_ready rises, so 0xC stays offered and is not accepted.
  - After out_ready=1, the outputs show 0xA, 0xB, 0xC with no loss.
  - stall_cnt=3.
- Flush: main and skid full (wb_ctl=2'b11, m_ctl=3'b101), in_valid=1, assert flush for one cycle ->
  - Next cycle: out_valid=0, out_wb_ctl=0, out_m_ctl=0, in_ready=1.
  - The beat offered during flush never appears at the outputs.
- Saturation: CNT_W=4 with out_ready=0 held for 20 cycles -> stall_cnt stops at 15. Asserting stall_cnt_clr together with a stall -> 0.
- Async reset: assert rst_n=0 between edges while skid is full -> all outputs and stall_cnt are 0 before the next edge; in_ready=1.
- Parameter sweep: DATA_W=64, RADDR_W=6 -> field values 0xFFFF_FFFF_0000_0001 and 6'd63 pass through unchanged.
